branch_resolve: RTL and testbench
=================================

# branch_resolve

Branch resolution unit for the 32-bit pipelined CPU; the consumer of the ALU's Z/V/C/N flag outputs. It latches flags into an architectural NZCV register and evaluates 4-bit branch conditions against them. On a taken branch it computes the target, delivers it to fetch over a valid/ready redirect handshake, then holds a pipeline flush for a fixed number of cycles. It sits between the EX stage (flags, branch descriptor) and the fetch/PC logic.

## Interface
- `FLUSH_CYCLES`, default 2: cycles of `flush` after the redirect is accepted; range 0..15.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flags_we` in 1: load Z/V/C/N into the flag register this cycle.
- `Z`, `V`, `C`, `N` in 1 each: ALU flags.
- `br_valid` in 1: branch descriptor valid.
- `br_ready` out 1: unit can accept a branch.
- `br_cond` in 4: condition code.
- `br_pc` in 32: PC of the branch instruction.
- `br_offset` in 32: signed word offset.
- `redirect_valid` out 1: redirect target valid.
- `redirect_ready` in 1: fetch accepts the redirect.
- `redirect_pc` out 32: branch target.
- `flush` out 1: squash younger pipeline stages.
- `flags_q` out 4: registered flags, ordered {N,Z,C,V}.
- `taken_cnt` out 16: saturating count of taken branches.

## Operation
- **Flag register**
  - Loads {N,Z,C,V} on any edge with `flags_we`=1, in every FSM state.
  - Otherwise it holds its value.
- **Condition codes**
  - 0 EQ: Z. 1 NE: ~Z.
  - 2 CS: C. 3 CC: ~C.
  - 4 MI: N. 5 PL: ~N.
  - 6 VS: V. 7 VC: ~V.
  - 8 HI: C&~Z. 9 LS: ~C|Z.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: ~Z&(N==V). 13 LE: Z|(N!=V).
  - 14 AL: 1. 15 NV: 0.
- **Target computation**
  - Target = `br_pc` + 4 + (`br_offset` << 2).
  - 32-bit arithmetic, wraps modulo 2^32; no overflow detection.
- **FSM states:** IDLE, REDIRECT, FLUSH.
  - IDLE: `br_ready`=1. On `br_valid`:
    - If taken: latch the target, go to REDIRECT, increment `taken_cnt` (saturates at 0xFFFF).
    - If not taken: consume the branch and stay in IDLE.
  - REDIRECT: `redirect_valid`=1, `flush`=1.
    - On `redirect_ready`: go to FLUSH with the counter loaded with FLUSH_CYCLES.
    - If FLUSH_CYCLES=0, go directly to IDLE instead.
  - FLUSH: `flush`=1; the counter decrements each cycle; go to IDLE on the edge where the counter reaches 1.
- `br_ready`=0 in REDIRECT and FLUSH. Upstream must hold `br_valid` and the descriptor stable until accepted.
- `redirect_pc` is stable while `redirect_valid`=1 and `redirect_ready`=0.
- Reset mid-operation: the FSM returns to IDLE immediately and all in-flight redirect state is discarded.

## Timing
- **Reset values:**
  - `br_ready`=1, `redirect_valid`=0, `flush`=0.
  - `redirect_pc`=0, `flags_q`=0, `taken_cnt`=0.
- `br_ready`, `redirect_valid` and `flush` are decoded from registered state. `redirect_pc`, `flags_q` and `taken_cnt` are registered.
- **Latency:**
  - Branch accepted at edge T: `redirect_valid`=1 during cycle T+1.
  - Flush spans from T+1 to FLUSH_CYCLES cycles after redirect acceptance.
  - If `redirect_ready` is held at 1, `flush` is high for exactly 1+FLUSH_CYCLES cycles.
- A flags update and branch acceptance on the same edge are legal; the evaluation source is set by the macro below.

## Configuration
- Macro `BRANCH_FLAG_BYPASS_EN`.
- **Defined:** when `flags_we`=1 in the cycle a branch is accepted, the condition is evaluated on the incoming Z/V/C/N. This forwards from a flag-setting instruction directly ahead of the branch.
- **Undefined:** the condition is always evaluated on `flags_q`, the value before the edge. The pipeline must then interlock one cycle.

## Structure
- A shared package holds:
  - the condition-code enum (EQ..NV, 4-bit);
  - the FSM state enum;
  - a packed flags struct {N,Z,C,V};
  - the constant for the PC increment, 4.
- One sub-module, `cond_eval`: combinational, maps condition code plus flags to `taken`. It is reusable for future predicated execution.

## Test plan
- **Reset:** assert `reset` mid-REDIRECT. All outputs return to reset values asynchronously; after release `br_ready`=1.
- **EQ taken, ready held high:** `flags_we` with Z=1, then `br_cond`=0, `br_pc`=0x100, `br_offset`=3.
  - `redirect_pc`=0x110 one cycle later.
  - `flush` high for 3 cycles; `taken_cnt`=1.
- **Signed conditions:** flags N=1,V=0. LT (11) is taken; GE (10) is not taken, with no `redirect_valid` and `br_ready` staying 1.
- **Backpressure:** hold `redirect_ready`=0 for 5 cycles.
  - `redirect_valid` and `redirect_pc` stay stable and `br_ready`=0.
  - A `flags_we` in this window updates `flags_q`.
- **Wrap and offsets:** `br_pc`=0xFFFFFFF8 with `br_offset`=1 gives 0x00000000. `br_offset`=-2 from 0x100 gives 0xFC.
- **Same-cycle flags and branch:** `flags_q` Z=0, incoming Z=1 with `flags_we`, EQ branch.
  - Taken with `BRANCH_FLAG_BYPASS_EN` defined.
  - Not taken without it.
- **Saturation:** after 0xFFFF taken branches, one more leaves `taken_cnt`=0xFFFF.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolution unit: condition codes, FSM states,
// the packed {N,Z,C,V} flag layout and the sequential PC increment.
package branch_resolve_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_CS = 4'd2,
      COND_CC = 4'd3,
      COND_MI = 4'd4,
      COND_PL = 4'd5,
      COND_VS = 4'd6,
      COND_VC = 4'd7,
      COND_HI = 4'd8,
      COND_LS = 4'd9,
      COND_GE = 4'd10,
      COND_LT = 4'd11,
      COND_GT = 4'd12,
      COND_LE = 4'd13,
      COND_AL = 4'd14,
      COND_NV = 4'd15
   } cond_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REDIRECT,
      ST_FLUSH
   } state_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   localparam logic [31:0] PC_INCR = 32'd4;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// Combinational condition-code evaluator: maps a 4-bit condition and the
// NZCV flags to a taken/not-taken decision.
module cond_eval
   import branch_resolve_pkg::*;
(
   input  logic [3:0] cond_i,
   input  flags_t     flags_i,
   output logic       taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (cond_e'(cond_i))
         COND_EQ: taken_o = flags_i.z;
         COND_NE: taken_o = ~flags_i.z;
         COND_CS: taken_o = flags_i.c;
         COND_CC: taken_o = ~flags_i.c;
         COND_MI: taken_o = flags_i.n;
         COND_PL: taken_o = ~flags_i.n;
         COND_VS: taken_o = flags_i.v;
         COND_VC: taken_o = ~flags_i.v;
         COND_HI: taken_o = flags_i.c & ~flags_i.z;
         COND_LS: taken_o = ~flags_i.c | flags_i.z;
         COND_GE: taken_o = (flags_i.n == flags_i.v);
         COND_LT: taken_o = (flags_i.n != flags_i.v);
         COND_GT: taken_o = ~flags_i.z & (flags_i.n == flags_i.v);
         COND_LE: taken_o = flags_i.z | (flags_i.n != flags_i.v);
         COND_AL: taken_o = 1'b1;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution unit: NZCV flag register, condition evaluation, redirect
// handshake to fetch and timed flush. Optional macro: BRANCH_FLAG_BYPASS_EN.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flags_we,
   input  logic        Z,
   input  logic        V,
   input  logic        C,
   input  logic        N,
   input  logic        br_valid,
   output logic        br_ready,
   input  logic [3:0]  br_cond,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_offset,
   output logic        redirect_valid,
   input  logic        redirect_ready,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic [3:0]  flags_q,
   output logic [15:0] taken_cnt
);

   state_e      state_q, state_d;
   logic [3:0]  fcnt_q, fcnt_d;
   logic [31:0] target_q, target_d;
   logic [15:0] taken_cnt_q, taken_cnt_d;
   flags_t      flag_reg_q, flag_reg_d;
   flags_t      flags_in;
   flags_t      eval_flags;
   logic        taken;
   logic [31:0] target_calc;

   assign flags_in = '{n: N, z: Z, c: C, v: V};

`ifdef BRANCH_FLAG_BYPASS_EN
   // Forward the incoming flags when they are written on the accepting edge.
   assign eval_flags = flags_we ? flags_in : flag_reg_q;
`else
   assign eval_flags = flag_reg_q;
`endif

   cond_eval u_cond_eval (
      .cond_i  (br_cond),
      .flags_i (eval_flags),
      .taken_o (taken)
   );

   assign target_calc = br_pc + PC_INCR + (br_offset << 2);
   assign flag_reg_d  = flags_we ? flags_in : flag_reg_q;

   always_comb begin
      state_d     = state_q;
      fcnt_d      = fcnt_q;
      target_d    = target_q;
      taken_cnt_d = taken_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (br_valid && taken) begin
               state_d     = ST_REDIRECT;
               target_d    = target_calc;
               taken_cnt_d = (taken_cnt_q == CNT_MAX) ? taken_cnt_q : taken_cnt_q + 16'd1;
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready) begin
               if (FLUSH_CYCLES == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_FLUSH;
                  fcnt_d  = 4'(FLUSH_CYCLES);
               end
            end
         end
         ST_FLUSH: begin
            fcnt_d = fcnt_q - 4'd1;
            if (fcnt_q == 4'd1) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         fcnt_q      <= '0;
         target_q    <= '0;
         taken_cnt_q <= '0;
         flag_reg_q  <= '0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         target_q    <= target_d;
         taken_cnt_q <= taken_cnt_d;
         flag_reg_q  <= flag_reg_d;
      end
   end

   assign br_ready       = (state_q == ST_IDLE);
   assign redirect_valid = (state_q == ST_REDIRECT);
   assign flush          = (state_q != ST_IDLE);
   assign redirect_pc    = target_q;
   assign flags_q        = flag_reg_q;
   assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (FLUSH_CYCLES=2); the
// same-cycle flag test follows BRANCH_FLAG_BYPASS_EN.
module tb_branch_resolve;

   logic        clk;
   logic        reset;
   logic        flags_we;
   logic        Z, V, C, N;
   logic        br_valid;
   logic        br_ready;
   logic [3:0]  br_cond;
   logic [31:0] br_pc;
   logic [31:0] br_offset;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [3:0]  flags_q;
   logic [15:0] taken_cnt;

   int unsigned errors;
   int unsigned checks;
   logic [15:0] exp_cnt;

   branch_resolve #(.FLUSH_CYCLES(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .flags_we       (flags_we),
      .Z              (Z),
      .V              (V),
      .C              (C),
      .N              (N),
      .br_valid       (br_valid),
      .br_ready       (br_ready),
      .br_cond        (br_cond),
      .br_pc          (br_pc),
      .br_offset      (br_offset),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .flags_q        (flags_q),
      .taken_cnt      (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic n, input logic z, input logic c, input logic v);
      N = n; Z = z; C = c; V = v;
      flags_we = 1'b1;
      tick();
      flags_we = 1'b0;
   endtask

   task automatic issue(input logic [3:0] cond, input logic [31:0] pc, input logic [31:0] off);
      br_valid  = 1'b1;
      br_cond   = cond;
      br_pc     = pc;
      br_offset = off;
      tick();
      br_valid  = 1'b0;
   endtask

   task automatic drain();
      int unsigned n;
      redirect_ready = 1'b1;
      n = 0;
      while (!br_ready && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!br_ready) begin
         errors++;
         $display("FAIL drain_timeout: br_ready=%0b after %0d cycles, required 1", br_ready, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++;
      if ({br_ready, redirect_valid, flush} !== 3'b100) begin
         errors++;
         $display("FAIL reset_ctrl: {rdy,rv,fl}=%b required 100", {br_ready, redirect_valid, flush});
      end
      tick(); tick();
      reset = 1'b0;
      tick();
      set_flags(1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (flags_q !== 4'hF) begin
         errors++;
         $display("FAIL flags_load: got %h required f", flags_q);
      end
      redirect_ready = 1'b0;
      issue(4'd14, 32'h40, 32'h0);
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h44) begin
         errors++;
         $display("FAIL pre_reset_redirect: rv=%0b pc=%h required 1 00000044", redirect_valid, redirect_pc);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({br_ready, redirect_valid, flush} !== 3'b100 || redirect_pc !== 32'h0 ||
          flags_q !== 4'h0 || taken_cnt !== 16'h0) begin
         errors++;
         $display("FAIL async_reset: rdy=%0b rv=%0b fl=%0b pc=%h flags=%h cnt=%h required 1 0 0 0 0 0",
                  br_ready, redirect_valid, flush, redirect_pc, flags_q, taken_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      checks++;
      if (br_ready !== 1'b1 || redirect_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: rdy=%0b rv=%0b required 1 0", br_ready, redirect_valid);
      end
      exp_cnt = 16'd0;
   endtask

   task automatic test_eq_taken();
      int unsigned nflush;
      set_flags(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (flags_q !== 4'b0100) begin
         errors++;
         $display("FAIL eq_flags: got %b required 0100", flags_q);
      end
      redirect_ready = 1'b1;
      issue(4'd0, 32'h100, 32'd3);
      exp_cnt++;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h110 || br_ready !== 1'b0) begin
         errors++;
         $display("FAIL eq_redirect: rv=%0b pc=%h rdy=%0b required 1 00000110 0", redirect_valid, redirect_pc, br_ready);
      end
      checks++;
      if (taken_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL eq_count: got %0d required %0d", taken_cnt, exp_cnt);
      end
      nflush = 0;
      while (flush && nflush < 20) begin
         nflush++;
         tick();
      end
      checks++;
      if (nflush != 3) begin
         errors++;
         $display("FAIL eq_flush_len: got %0d cycles required 3", nflush);
      end
      checks++;
      if (br_ready !== 1'b1) begin
         errors++;
         $display("FAIL eq_back_idle: br_ready=%0b required 1", br_ready);
      end
   endtask

   task automatic test_signed();
      set_flags(1'b1, 1'b0, 1'b0, 1'b0);
      redirect_ready = 1'b1;
      issue(4'd11, 32'h200, 32'h0);
      exp_cnt++;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204) begin
         errors++;
         $display("FAIL lt_taken: rv=%0b pc=%h required 1 00000204", redirect_valid, redirect_pc);
      end
      drain();
      issue(4'd10, 32'h300, 32'h0);
      checks++;
      if (redirect_valid !== 1'b0 || br_ready !== 1'b1 || flush !== 1'b0) begin
         errors++;
         $display("FAIL ge_not_taken: rv=%0b rdy=%0b fl=%0b required 0 1 0", redirect_valid, br_ready, flush);
      end
      checks++;
      if (taken_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL signed_count: got %0d required %0d", taken_cnt, exp_cnt);
      end
   endtask

   task automatic test_backpressure();
      redirect_ready = 1'b0;
      issue(4'd14, 32'h1000, 32'h10);
      exp_cnt++;
      br_pc     = 32'hDEAD0000;
      br_offset = 32'h7;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            set_flags(1'b0, 1'b0, 1'b1, 1'b1);
         end else begin
            tick();
         end
         checks++;
         if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1044 || br_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: rv=%0b pc=%h rdy=%0b required 1 00001044 0",
                     i, redirect_valid, redirect_pc, br_ready);
         end
      end
      checks++;
      if (flags_q !== 4'b0011) begin
         errors++;
         $display("FAIL bp_flags: got %b required 0011", flags_q);
      end
      drain();
      checks++;
      if (taken_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL bp_count: got %0d required %0d", taken_cnt, exp_cnt);
      end
   endtask

   task automatic test_wrap_offsets();
      redirect_ready = 1'b1;
      issue(4'd14, 32'hFFFF_FFF8, 32'd1);
      exp_cnt++;
      checks++;
      if (redirect_pc !== 32'h0000_0000) begin
         errors++;
         $display("FAIL wrap_pc: got %h required 00000000", redirect_pc);
      end
      drain();
      issue(4'd14, 32'h100, 32'hFFFF_FFFE);
      exp_cnt++;
      checks++;
      if (redirect_pc !== 32'h0000_00FC) begin
         errors++;
         $display("FAIL neg_offset_pc: got %h required 000000fc", redirect_pc);
      end
      drain();
   endtask

   task automatic test_same_cycle();
      logic exp_taken;
`ifdef BRANCH_FLAG_BYPASS_EN
      exp_taken = 1'b1;
`else
      exp_taken = 1'b0;
`endif
      set_flags(1'b0, 1'b0, 1'b0, 1'b0);
      redirect_ready = 1'b1;
      N = 1'b0; Z = 1'b1; C = 1'b0; V = 1'b0;
      flags_we = 1'b1;
      issue(4'd0, 32'h300, 32'h0);
      flags_we = 1'b0;
      if (exp_taken) exp_cnt++;
      checks++;
      if (redirect_valid !== exp_taken) begin
         errors++;
         $display("FAIL same_cycle_taken: rv=%0b required %0b", redirect_valid, exp_taken);
      end
      checks++;
      if (flags_q !== 4'b0100) begin
         errors++;
         $display("FAIL same_cycle_flags: got %b required 0100", flags_q);
      end
      drain();
      checks++;
      if (taken_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL same_cycle_count: got %0d required %0d", taken_cnt, exp_cnt);
      end
   endtask

   task automatic test_saturation();
      logic [15:0] exp_sat [3];
      exp_sat[0] = 16'hFFFE;
      exp_sat[1] = 16'hFFFF;
      exp_sat[2] = 16'hFFFF;
      // Preload near the ceiling instead of issuing 65533 real branches.
      force dut.taken_cnt_q = 16'hFFFD;
      #1;
      release dut.taken_cnt_q;
      redirect_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(4'd14, 32'h400, 32'h0);
         checks++;
         if (taken_cnt !== exp_sat[i]) begin
            errors++;
            $display("FAIL sat_count[%0d]: got %h required %h", i, taken_cnt, exp_sat[i]);
         end
         drain();
      end
   endtask

   task automatic test_back_to_back();
      redirect_ready = 1'b1;
      set_flags(1'b0, 1'b0, 1'b1, 1'b0);
      issue(4'd15, 32'h500, 32'h0);
      checks++;
      if (redirect_valid !== 1'b0 || br_ready !== 1'b1) begin
         errors++;
         $display("FAIL nv_not_taken: rv=%0b rdy=%0b required 0 1", redirect_valid, br_ready);
      end
      issue(4'd8, 32'h600, 32'h2);
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h60C) begin
         errors++;
         $display("FAIL hi_taken: rv=%0b pc=%h required 1 0000060c", redirect_valid, redirect_pc);
      end
      drain();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      exp_cnt = '0;
      reset = 1'b1;
      flags_we = 1'b0;
      {N, Z, C, V} = 4'b0000;
      br_valid = 1'b0;
      br_cond = 4'd0;
      br_pc = '0;
      br_offset = '0;
      redirect_ready = 1'b0;
      test_reset();
      test_eq_taken();
      test_signed();
      test_backpressure();
      test_wrap_offsets();
      test_same_cycle();
      test_back_to_back();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
